acq_sequencer: RTL and testbench
================================

// Module: acq_sequencer
// PURPOSE
//  Parametrised ADC acquisition sequencer, successor to the single-shot config/process FSM.
//  Forwards SPI config transfers, drives per-channel relay pairs, waits a programmable settle
//  time, then gates iddr_clk_en_o for exactly N sweeps, aligned to sweep boundaries.
//  Adds abort, a one-deep pending-transfer buffer and sweep progress reporting.
// PARAMETERS
//  TX_W      24  SPI transmit word width
//  RX_W      8   SPI receive word width
//  NUM_CH    2   analogue channels (relay pair sets)
//  CNT_W     32  sweep counter width
//  SETTLE_W  16  relay settle counter width
// PORTS
//  clk_i             in  1         single clock
//  rst_clk_i         in  1         synchronous, active-high reset
//  tx_reg_i          in  TX_W      SPI word from host
//  transfer_start_i  in  1         async level; rising edge requests an SPI transfer
//  tx_reg_o          out TX_W      word to SPI controller
//  transfer_start_o  out 1         1-cycle start pulse to SPI controller
//  rx_reg_i          in  RX_W      SPI read data
//  transfer_done_i   in  1         1-cycle done pulse from SPI controller
//  rx_reg_o          out RX_W      rx_reg_i captured on transfer_done_i
//  transfer_done_o   out 1         transfer_done_i delayed 1 cycle
//  config_done_i     in  1         async level; rising edge arms acquisition
//  abort_i           in  1         sync pulse; cancels settle/arm/acquire
//  coupling_i        in  NUM_CH    1=AC, 0=DC per channel
//  gain_i            in  NUM_CH    1=high gain per channel
//  settle_cycles_i   in  SETTLE_W  relay settle time in clk cycles
//  sweep_num_i       in  CNT_W     sweeps to acquire (0 treated as 1)
//  sweep_complete_i  in  1         1-cycle end-of-sweep pulse
//  iddr_clk_en_o     out 1         capture enable to CDC fifo
//  sweep_cnt_o       out CNT_W     sweeps completed in current/last run
//  acq_done_o        out 1         1-cycle pulse on normal completion
//  busy_o            out 1         state != IDLE
//  com_sc_h_t_o/com_sc_l_t_o  out 1       common relay pair
//  ac_h_t_o/ac_l_t_o          out NUM_CH  coupling relay pairs
//  gain_h_t_o/gain_l_t_o      out NUM_CH  gain relay pairs
// BEHAVIOUR
//  Reset: state IDLE; all data/pulse outputs, sweep_cnt_o, iddr_clk_en_o, pending flag 0; relays 1.
//  Async inputs: 2-flop sync + edge detect; edge-history flop resets to 1 (level high across reset -> no edge).
//  States: IDLE, SPI_XFER, SETTLE, ARM, ACQUIRE.
//  IDLE: cfg edge -> latch coupling/gain/sweep_num, clear sweep_cnt_o, load settle ctr, -> SETTLE.
//   else xfer edge or pending -> tx_reg_o<=tx_reg_i, transfer_start_o=1 one cycle, clear pending, -> SPI_XFER.
//   cfg and xfer edge same cycle: cfg wins, xfer sets pending.
//  SPI_XFER: wait transfer_done_i -> IDLE; abort_i ignored here.
//  Xfer edge outside IDLE sets pending; second edge while pending is dropped.
//  SETTLE: decrement each cycle; at 0 -> ARM (settle_cycles_i=0: ARM next cycle).
//  ARM: sweep_complete_i -> ACQUIRE; iddr_clk_en_o=1 from next cycle.
//  ACQUIRE: each sweep_complete_i increments sweep_cnt_o; on reaching N: iddr_clk_en_o=0,
//   acq_done_o pulse, -> IDLE, all same edge. sweep_cnt_o holds N until next arm.
//  abort_i in SETTLE/ARM/ACQUIRE: next cycle IDLE, en=0, no acq_done_o, sweep_cnt_o holds.
//  Relays (combinational on state, latched modes): IDLE/SPI_XFER all 1.
//   Other states, ch i AC: ac_h=0,ac_l=1; DC: ac_h=1,ac_l=0. Gain 1: h=0,l=1; 0: h=1,l=0.
//   com pair follows latched coupling[0]: AC h=1,l=0; DC h=0,l=1.
//  rx_reg_o/transfer_done_o registered pass-through, independent of state.
// TESTING
//  SPI: tx_reg_i=24'hA5_0312, rising transfer_start_i -> one start pulse, tx_reg_o=24'hA50312; done -> IDLE.
//  Acquire: sweep_num=3, settle=10, coupling=2'b01 -> 10 settle cycles, en from 1st sweep pulse, 3 more, acq_done.
//  sweep_num=0 and settle=0 -> exactly one sweep captured, acq_done asserted, sweep_cnt_o=1.
//  abort after 2 of 5 sweeps -> en low next cycle, no acq_done, sweep_cnt_o=2, relays all 1.
//  Two xfer edges during ACQUIRE -> exactly one transfer issued on return to IDLE.
//  rst_clk_i mid-ACQUIRE with config_done_i held high -> IDLE, outputs reset, no re-arm after release.

Source files
------------

// File: rtl/acq_sequencer.sv
// acq_sequencer: SPI config forwarding, relay drive, settle wait and sweep-aligned capture gating.
module acq_sequencer #(
  parameter int TX_W     = 24,
  parameter int RX_W     = 8,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  parameter int SETTLE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_clk_i,
  input  logic [TX_W-1:0]     tx_reg_i,
  input  logic                transfer_start_i,
  output logic [TX_W-1:0]     tx_reg_o,
  output logic                transfer_start_o,
  input  logic [RX_W-1:0]     rx_reg_i,
  input  logic                transfer_done_i,
  output logic [RX_W-1:0]     rx_reg_o,
  output logic                transfer_done_o,
  input  logic                config_done_i,
  input  logic                abort_i,
  input  logic [NUM_CH-1:0]   coupling_i,
  input  logic [NUM_CH-1:0]   gain_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  input  logic [CNT_W-1:0]    sweep_num_i,
  input  logic                sweep_complete_i,
  output logic                iddr_clk_en_o,
  output logic [CNT_W-1:0]    sweep_cnt_o,
  output logic                acq_done_o,
  output logic                busy_o,
  output logic                com_sc_h_t_o,
  output logic                com_sc_l_t_o,
  output logic [NUM_CH-1:0]   ac_h_t_o,
  output logic [NUM_CH-1:0]   ac_l_t_o,
  output logic [NUM_CH-1:0]   gain_h_t_o,
  output logic [NUM_CH-1:0]   gain_l_t_o
);
  typedef enum logic [2:0] {IDLE, SPI_XFER, SETTLE, ARM, ACQUIRE} state_t;
  state_t              state_q, state_d;
  logic [1:0]          xfer_sync_q, cfg_sync_q;
  logic                xfer_prev_q, cfg_prev_q;
  logic                xfer_edge, cfg_edge;
  logic                pend_q, pend_d;
  logic [TX_W-1:0]     tx_q, tx_d;
  logic                start_q, start_d;
  logic [RX_W-1:0]     rx_q;
  logic                done_q;
  logic [NUM_CH-1:0]   cpl_q, cpl_d, gain_q, gain_d;
  logic [CNT_W-1:0]    num_q, num_d, cnt_q, cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                en_q, en_d;
  logic                acq_done_q, acq_done_d;
  logic                active;
  // Synchronisers reset high so a level already high across reset never looks like an edge
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      xfer_sync_q <= '1;
      cfg_sync_q  <= '1;
      xfer_prev_q <= 1'b1;
      cfg_prev_q  <= 1'b1;
    end else begin
      xfer_sync_q <= {xfer_sync_q[0], transfer_start_i};
      cfg_sync_q  <= {cfg_sync_q[0], config_done_i};
      xfer_prev_q <= xfer_sync_q[1];
      cfg_prev_q  <= cfg_sync_q[1];
    end
  end
  assign xfer_edge = xfer_sync_q[1] & ~xfer_prev_q;
  assign cfg_edge  = cfg_sync_q[1] & ~cfg_prev_q;
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      tx_q       <= '0;
      start_q    <= 1'b0;
      rx_q       <= '0;
      done_q     <= 1'b0;
      cpl_q      <= '0;
      gain_q     <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      settle_q   <= '0;
      en_q       <= 1'b0;
      acq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      tx_q       <= tx_d;
      start_q    <= start_d;
      rx_q       <= transfer_done_i ? rx_reg_i : rx_q;
      done_q     <= transfer_done_i;
      cpl_q      <= cpl_d;
      gain_q     <= gain_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      en_q       <= en_d;
      acq_done_q <= acq_done_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | (xfer_edge && state_q != IDLE);
    tx_d       = tx_q;
    start_d    = 1'b0;
    cpl_d      = cpl_q;
    gain_d     = gain_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    en_d       = en_q;
    acq_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_edge) begin
          cpl_d    = coupling_i;
          gain_d   = gain_i;
          num_d    = (sweep_num_i == '0) ? CNT_W'(1) : sweep_num_i;
          cnt_d    = '0;
          settle_d = settle_cycles_i;
          pend_d   = pend_q | xfer_edge;
          state_d  = SETTLE;
        end else if (xfer_edge || pend_q) begin
          tx_d    = tx_reg_i;
          start_d = 1'b1;
          pend_d  = 1'b0;
          state_d = SPI_XFER;
        end
      end
      SPI_XFER: state_d = transfer_done_i ? IDLE : SPI_XFER;
      // A load of 0 or 1 both give a single settle cycle
      SETTLE: begin
        if (abort_i) state_d = IDLE;
        else if (settle_q <= SETTLE_W'(1)) state_d = ARM;
        else settle_d = settle_q - SETTLE_W'(1);
      end
      ARM: begin
        if (abort_i) state_d = IDLE;
        else if (sweep_complete_i) begin
          en_d    = 1'b1;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (abort_i) begin
          en_d    = 1'b0;
          state_d = IDLE;
        end else if (sweep_complete_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == num_q) begin
            en_d       = 1'b0;
            acq_done_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign active           = (state_q == SETTLE) || (state_q == ARM) || (state_q == ACQUIRE);
  assign tx_reg_o         = tx_q;
  assign transfer_start_o = start_q;
  assign rx_reg_o         = rx_q;
  assign transfer_done_o  = done_q;
  assign iddr_clk_en_o    = en_q;
  assign sweep_cnt_o      = cnt_q;
  assign acq_done_o       = acq_done_q;
  assign busy_o           = state_q != IDLE;
  assign com_sc_h_t_o     = active ? cpl_q[0] : 1'b1;
  assign com_sc_l_t_o     = active ? ~cpl_q[0] : 1'b1;
  assign ac_h_t_o         = active ? ~cpl_q : '1;
  assign ac_l_t_o         = active ? cpl_q : '1;
  assign gain_h_t_o       = active ? ~gain_q : '1;
  assign gain_l_t_o       = active ? gain_q : '1;
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed scenario tests for acq_sequencer with hand-computed expectations.
module tb_acq_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_clk_i = 1'b1;
  logic [23:0] tx_reg_i = '0;
  logic        transfer_start_i = 1'b0;
  logic [23:0] tx_reg_o;
  logic        transfer_start_o;
  logic [7:0]  rx_reg_i = '0;
  logic        transfer_done_i = 1'b0;
  logic [7:0]  rx_reg_o;
  logic        transfer_done_o;
  logic        config_done_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [1:0]  coupling_i = '0;
  logic [1:0]  gain_i = '0;
  logic [15:0] settle_cycles_i = '0;
  logic [31:0] sweep_num_i = '0;
  logic        sweep_complete_i = 1'b0;
  logic        iddr_clk_en_o;
  logic [31:0] sweep_cnt_o;
  logic        acq_done_o, busy_o, com_sc_h_t_o, com_sc_l_t_o;
  logic [1:0]  ac_h_t_o, ac_l_t_o, gain_h_t_o, gain_l_t_o;
  int tests = 0;
  int fails = 0;

  acq_sequencer dut (
    .clk_i(clk_i), .rst_clk_i(rst_clk_i), .tx_reg_i(tx_reg_i), .transfer_start_i(transfer_start_i),
    .tx_reg_o(tx_reg_o), .transfer_start_o(transfer_start_o), .rx_reg_i(rx_reg_i),
    .transfer_done_i(transfer_done_i), .rx_reg_o(rx_reg_o), .transfer_done_o(transfer_done_o),
    .config_done_i(config_done_i), .abort_i(abort_i), .coupling_i(coupling_i), .gain_i(gain_i),
    .settle_cycles_i(settle_cycles_i), .sweep_num_i(sweep_num_i), .sweep_complete_i(sweep_complete_i),
    .iddr_clk_en_o(iddr_clk_en_o), .sweep_cnt_o(sweep_cnt_o), .acq_done_o(acq_done_o), .busy_o(busy_o),
    .com_sc_h_t_o(com_sc_h_t_o), .com_sc_l_t_o(com_sc_l_t_o), .ac_h_t_o(ac_h_t_o), .ac_l_t_o(ac_l_t_o),
    .gain_h_t_o(gain_h_t_o), .gain_l_t_o(gain_l_t_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sweep_pulse();
    sweep_complete_i = 1'b1;
    tick();
    sweep_complete_i = 1'b0;
  endtask

  // Raise config_done_i and wait (bounded) until the sequencer leaves IDLE
  task automatic arm_run(input logic [31:0] n, input logic [15:0] s, input logic [1:0] c, input logic [1:0] g);
    bit seen = 0;
    sweep_num_i = n; settle_cycles_i = s; coupling_i = c; gain_i = g;
    config_done_i = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = busy_o;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL arm_timeout: busy_o=%b required 1 within 10 cycles", busy_o); end
  endtask

  task automatic test_reset();
    rst_clk_i = 1'b1;
    repeat (3) tick();
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    tests++; if (iddr_clk_en_o !== 1'b0 || acq_done_o !== 1'b0 || transfer_start_o !== 1'b0) begin
      fails++; $display("FAIL reset_pulses: en=%b done=%b start=%b exp 000", iddr_clk_en_o, acq_done_o, transfer_start_o); end
    tests++; if (sweep_cnt_o !== 32'd0 || tx_reg_o !== 24'd0) begin
      fails++; $display("FAIL reset_data: cnt=%0d tx=%h exp 0 0", sweep_cnt_o, tx_reg_o); end
    tests++; if ({com_sc_h_t_o, com_sc_l_t_o, ac_h_t_o, ac_l_t_o, gain_h_t_o, gain_l_t_o} !== 10'h3FF) begin
      fails++; $display("FAIL reset_relays: got %b exp all ones", {com_sc_h_t_o, com_sc_l_t_o, ac_h_t_o, ac_l_t_o, gain_h_t_o, gain_l_t_o}); end
    rst_clk_i = 1'b0;
    repeat (4) tick();
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_idle_after_release: busy=%b exp 0", busy_o); end
  endtask

  task automatic test_rx_passthrough();
    rx_reg_i = 8'h3C; transfer_done_i = 1'b1;
    tick();
    transfer_done_i = 1'b0; rx_reg_i = 8'h00;
    tests++; if (transfer_done_o !== 1'b1 || rx_reg_o !== 8'h3C) begin
      fails++; $display("FAIL rx_capture: done=%b rx=%h exp 1 3c", transfer_done_o, rx_reg_o); end
    tick();
    tests++; if (transfer_done_o !== 1'b0 || rx_reg_o !== 8'h3C) begin
      fails++; $display("FAIL rx_hold: done=%b rx=%h exp 0 3c", transfer_done_o, rx_reg_o); end
  endtask

  task automatic test_spi();
    int starts = 0;
    logic [23:0] tx_seen = '0;
    logic busy_seen = 1'b0;
    tx_reg_i = 24'hA5_0312;
    transfer_start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (transfer_start_o) begin starts++; tx_seen = tx_reg_o; busy_seen = busy_o; end
    end
    transfer_start_i = 1'b0;
    tests++; if (starts !== 1) begin fails++; $display("FAIL spi_start_count: got %0d exp 1", starts); end
    tests++; if (tx_seen !== 24'hA50312) begin fails++; $display("FAIL spi_tx_word: got %h exp a50312", tx_seen); end
    tests++; if (busy_seen !== 1'b1 || busy_o !== 1'b1) begin
      fails++; $display("FAIL spi_wait_busy: at_start=%b now=%b exp 1 1", busy_seen, busy_o); end
    rx_reg_i = 8'h5A; transfer_done_i = 1'b1;
    tick();
    transfer_done_i = 1'b0;
    tests++; if (busy_o !== 1'b0 || rx_reg_o !== 8'h5A) begin
      fails++; $display("FAIL spi_done: busy=%b rx=%h exp 0 5a", busy_o, rx_reg_o); end
    repeat (3) tick();
  endtask

  task automatic test_acquire();
    arm_run(32'd3, 16'd10, 2'b01, 2'b10);
    tests++; if ({com_sc_h_t_o, com_sc_l_t_o} !== 2'b10 || ac_h_t_o !== 2'b10 || ac_l_t_o !== 2'b01) begin
      fails++; $display("FAIL acq_coupling_relays: com=%b%b ac_h=%b ac_l=%b exp 10 10 01", com_sc_h_t_o, com_sc_l_t_o, ac_h_t_o, ac_l_t_o); end
    tests++; if (gain_h_t_o !== 2'b01 || gain_l_t_o !== 2'b10) begin
      fails++; $display("FAIL acq_gain_relays: h=%b l=%b exp 01 10", gain_h_t_o, gain_l_t_o); end
    repeat (9) tick();
    sweep_pulse();
    tests++; if (iddr_clk_en_o !== 1'b0) begin fails++; $display("FAIL acq_settle_len: en=%b exp 0 on 10th settle cycle", iddr_clk_en_o); end
    sweep_pulse();
    tests++; if (iddr_clk_en_o !== 1'b1 || sweep_cnt_o !== 32'd0) begin
      fails++; $display("FAIL acq_align: en=%b cnt=%0d exp 1 0", iddr_clk_en_o, sweep_cnt_o); end
    sweep_pulse();
    tick();
    sweep_pulse();
    tests++; if (sweep_cnt_o !== 32'd2 || iddr_clk_en_o !== 1'b1 || acq_done_o !== 1'b0) begin
      fails++; $display("FAIL acq_mid: cnt=%0d en=%b done=%b exp 2 1 0", sweep_cnt_o, iddr_clk_en_o, acq_done_o); end
    sweep_pulse();
    tests++; if (sweep_cnt_o !== 32'd3 || iddr_clk_en_o !== 1'b0 || acq_done_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL acq_finish: cnt=%0d en=%b done=%b busy=%b exp 3 0 1 0", sweep_cnt_o, iddr_clk_en_o, acq_done_o, busy_o); end
    tick();
    tests++; if (acq_done_o !== 1'b0 || sweep_cnt_o !== 32'd3 || ac_h_t_o !== 2'b11) begin
      fails++; $display("FAIL acq_after: done=%b cnt=%0d ac_h=%b exp 0 3 11", acq_done_o, sweep_cnt_o, ac_h_t_o); end
    config_done_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_zero_sweeps();
    arm_run(32'd0, 16'd0, 2'b00, 2'b00);
    tests++; if ({com_sc_h_t_o, com_sc_l_t_o} !== 2'b01 || ac_h_t_o !== 2'b11 || gain_l_t_o !== 2'b00) begin
      fails++; $display("FAIL zero_dc_relays: com=%b%b ac_h=%b gain_l=%b exp 01 11 00", com_sc_h_t_o, com_sc_l_t_o, ac_h_t_o, gain_l_t_o); end
    tick();
    sweep_pulse();
    tests++; if (iddr_clk_en_o !== 1'b1) begin fails++; $display("FAIL zero_en: en=%b exp 1", iddr_clk_en_o); end
    sweep_pulse();
    tests++; if (sweep_cnt_o !== 32'd1 || iddr_clk_en_o !== 1'b0 || acq_done_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL zero_finish: cnt=%0d en=%b done=%b busy=%b exp 1 0 1 0", sweep_cnt_o, iddr_clk_en_o, acq_done_o, busy_o); end
    config_done_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_abort();
    bit done_seen = 0;
    arm_run(32'd5, 16'd2, 2'b10, 2'b01);
    repeat (2) tick();
    sweep_pulse();
    sweep_pulse();
    sweep_pulse();
    tests++; if (sweep_cnt_o !== 32'd2 || iddr_clk_en_o !== 1'b1) begin
      fails++; $display("FAIL abort_pre: cnt=%0d en=%b exp 2 1", sweep_cnt_o, iddr_clk_en_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    done_seen = acq_done_o;
    tests++; if (iddr_clk_en_o !== 1'b0 || busy_o !== 1'b0 || sweep_cnt_o !== 32'd2) begin
      fails++; $display("FAIL abort_state: en=%b busy=%b cnt=%0d exp 0 0 2", iddr_clk_en_o, busy_o, sweep_cnt_o); end
    tests++; if ({com_sc_h_t_o, com_sc_l_t_o, ac_h_t_o, ac_l_t_o, gain_h_t_o, gain_l_t_o} !== 10'h3FF) begin
      fails++; $display("FAIL abort_relays: got %b exp all ones", {com_sc_h_t_o, com_sc_l_t_o, ac_h_t_o, ac_l_t_o, gain_h_t_o, gain_l_t_o}); end
    tick();
    done_seen = done_seen | acq_done_o;
    tests++; if (done_seen !== 1'b0) begin fails++; $display("FAIL abort_no_done: acq_done seen=%b exp 0", done_seen); end
    config_done_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_pending();
    int early = 0;
    int starts = 0;
    arm_run(32'd1, 16'd0, 2'b00, 2'b00);
    tick();
    sweep_pulse();
    tx_reg_i = 24'h12_3456;
    for (int k = 0; k < 2; k++) begin
      transfer_start_i = 1'b1;
      repeat (4) begin tick(); early += int'(transfer_start_o); end
      transfer_start_i = 1'b0;
      repeat (4) begin tick(); early += int'(transfer_start_o); end
    end
    tests++; if (early !== 0 || busy_o !== 1'b1) begin
      fails++; $display("FAIL pend_hold: starts=%0d busy=%b exp 0 1", early, busy_o); end
    sweep_pulse();
    tests++; if (acq_done_o !== 1'b1) begin fails++; $display("FAIL pend_acq_done: got %b exp 1", acq_done_o); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (transfer_start_o) begin
        starts++;
        tests++; if (tx_reg_o !== 24'h123456) begin fails++; $display("FAIL pend_tx: got %h exp 123456", tx_reg_o); end
      end
    end
    tests++; if (starts !== 1) begin fails++; $display("FAIL pend_count: got %0d exp 1", starts); end
    transfer_done_i = 1'b1;
    tick();
    transfer_done_i = 1'b0;
    repeat (10) tick();
    tests++; if (busy_o !== 1'b0 || transfer_start_o !== 1'b0) begin
      fails++; $display("FAIL pend_idle: busy=%b start=%b exp 0 0", busy_o, transfer_start_o); end
    config_done_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    bit rearm = 0;
    arm_run(32'd5, 16'd0, 2'b11, 2'b11);
    tick();
    sweep_pulse();
    sweep_pulse();
    tests++; if (iddr_clk_en_o !== 1'b1 || sweep_cnt_o !== 32'd1) begin
      fails++; $display("FAIL rstmid_pre: en=%b cnt=%0d exp 1 1", iddr_clk_en_o, sweep_cnt_o); end
    rst_clk_i = 1'b1;
    repeat (2) tick();
    tests++; if (busy_o !== 1'b0 || iddr_clk_en_o !== 1'b0 || sweep_cnt_o !== 32'd0 || ac_l_t_o !== 2'b11) begin
      fails++; $display("FAIL rstmid_state: busy=%b en=%b cnt=%0d ac_l=%b exp 0 0 0 11", busy_o, iddr_clk_en_o, sweep_cnt_o, ac_l_t_o); end
    rst_clk_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      rearm = rearm | busy_o;
    end
    tests++; if (rearm !== 1'b0) begin fails++; $display("FAIL rstmid_rearm: busy seen=%b exp 0", rearm); end
    config_done_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rx_passthrough();
    test_spi();
    test_acquire();
    test_zero_sweeps();
    test_abort();
    test_pending();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
